alu_bist: RTL and testbench
===========================

# alu_bist

Built-in self-test sequencer for the single-cycle core's combinational ALU. It drives the ALU's input interface: instruction word, alu_op and two operands. It encodes every supported R-format, immediate-arithmetic, load-address and branch-compare operation, feeding LFSR-generated operands. Each ALU result is compressed into a MISR signature, which is compared against a golden value. It sits beside the ALU in test mode and is muxed onto the ALU inputs ahead of the datapath.

## Interface
- N, 32: operand and result width.
- INSTRUCTION_LEN, 32: width of the encoded instruction word.
- PATTERNS, 256: operand pairs applied per operation; legal range 1..65535.
- EXPECTED_SIGNATURE, 32'h0000_0000: golden MISR value; the integrator sets it from the reference model.
- clk  in  1  clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a run.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next accepted start or reset.
- pass  out  1  signature == EXPECTED_SIGNATURE; valid only while done=1, otherwise 0.
- signature  out  N  current MISR value.
- alu_instruction  out  INSTRUCTION_LEN  encoded instruction presented to the ALU.
- alu_op  out  2  ALU operation class.
- alu_data_1 / alu_data_2  out  N  operands.
- alu_data_out  in  N  ALU result.
- alu_overflow  in  1  ALU carry/overflow bit.

## Operation
- FSM states: IDLE, RUN, COMPARE, DONE.
  - IDLE→RUN on start.
  - RUN→COMPARE after the last pattern of the last operation.
  - COMPARE→DONE unconditionally.
  - DONE→RUN on start.
  - start is ignored in RUN and COMPARE.
- On entry to RUN:
  - op_idx=0, pat_cnt=0.
  - LFSR1=32'h0000_0001, LFSR2=32'hACE1_0001.
  - signature=32'hFFFF_FFFF.
- Operation table, op_idx 0..20:
  - 0–9 R-format, alu_op=10, opcode 7'd51: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - 10–18 immediate-arithmetic, alu_op=10, opcode 7'd19: ADDI, ANDI, ORI, XORI, SLLI, SRLI, SRAI, SLTI, SLTIU.
  - 19: alu_op=00, opcode 7'd3.
  - 20: alu_op=01, opcode 7'd99.
- Instruction encoding:
  - funct7 in [31:25], funct3 in [14:12], opcode in [6:0]; all other bits zero.
  - SUB and SRA/SRAI use funct7=7'h20; every other operation uses funct7=0.
- LFSR and MISR polynomial POLY=32'h04C1_1DB7.
  - LFSR step: next = {l[30:0],0} ^ (l[31] ? POLY : 0).
  - MISR step: next = {s[30:0],0} ^ (s[31] ? POLY : 0) ^ alu_data_out.
- Each RUN cycle: MISR absorbs the current result, both LFSRs step, and pat_cnt increments.
  - pat_cnt wraps at PATTERNS-1; op_idx increments on that wrap.
- alu_data_1 and alu_data_2 are the LFSR registers themselves, with no extra stage.
- reset, in any state including mid-RUN:
  - state=IDLE.
  - busy=done=pass=0.
  - signature=32'hFFFF_FFFF.
  - alu_instruction=0, alu_op=00, alu_data_1=alu_data_2=0.
  - op_idx=pat_cnt=0.
- In IDLE and DONE, all ALU-side outputs are held at their reset values.

## Timing
- start sampled high at edge t: busy=1 from t+1, and pattern 0 of op 0 is presented during cycle t+1.
- The ALU is combinational, so the result of the pattern presented in cycle k is captured at the edge ending cycle k. Throughput is one pattern per cycle.
- RUN lasts exactly 21×PATTERNS cycles; COMPARE lasts 1 cycle.
- busy=1 through RUN and COMPARE.
- done=1 and pass become valid on the first DONE cycle.
- Total latency from the start edge to done: 21×PATTERNS+2 cycles.

## Configuration
- ALU_BIST_OVF_EN defined: alu_overflow is XORed into bit 0 of the MISR input word each RUN cycle.
- ALU_BIST_OVF_EN undefined: alu_overflow is unused, and the signature depends on alu_data_out only.

## Structure
- Package alu_bist_pkg holds:
  - opcode constants (51, 19, 3, 99), funct3/funct7 encodings and POLY;
  - the FSM state enum;
  - the 21-entry operation table (alu_op, opcode, funct3, funct7).
- One sub-module, bist_lfsr (parameterised seed; enable and load inputs), instantiated twice for the operands.
- The MISR stays inline.

## Test plan
- Reset: assert reset for 2 cycles. Required: busy=done=pass=0, signature=32'hFFFF_FFFF, alu_instruction=0, alu_op=00.
- Sequencing, PATTERNS=1, with start:
  - Cycle t+1: alu_instruction=32'h0000_0033, alu_op=10, alu_data_1=32'h1, alu_data_2=32'hACE1_0001.
  - Op 1 presents 32'h4000_0033; op 16 presents 32'h4000_5013; op 20 presents 32'h0000_0063 with alu_op=01.
  - done rises at t+23.
- Golden ALU with EXPECTED_SIGNATURE from the model: pass=1. Same run with alu_data_out[0] stuck-at-0: pass=0, signature differs.
- Reset at cycle 100 of a PATTERNS=256 run: IDLE next cycle with all outputs at reset values. A fresh start reproduces the golden signature bit-exactly.
- start pulsed during RUN: ignored, completion cycle unchanged. start pulsed in DONE: done clears next cycle and the run restarts.
- Overflow forced to 1:
  - With ALU_BIST_OVF_EN, the signature differs from the golden value.
  - Without it, the signature is unchanged.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// Shared encodings for the ALU self-test: opcodes, funct fields, polynomial, FSM states, op table.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package alu_bist_pkg;

    localparam logic [6:0] OPC_R      = 7'd51;
    localparam logic [6:0] OPC_IMM    = 7'd19;
    localparam logic [6:0] OPC_LOAD   = 7'd3;
    localparam logic [6:0] OPC_BRANCH = 7'd99;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;
    localparam logic [2:0] F3_LW   = 3'd2;
    localparam logic [2:0] F3_BEQ  = 3'd0;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    localparam logic [31:0] POLY    = 32'h04C1_1DB7;
    localparam int          NUM_OPS = 21;

    typedef enum logic [1:0] {IDLE, RUN, COMPARE, DONE} state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } op_entry_t;

    function automatic op_entry_t op_table(input logic [4:0] idx);
        op_entry_t e;
        case (idx)
            5'd0:    e = '{ALUOP_FN,  OPC_R,      F3_ADD,  F7_BASE};
            5'd1:    e = '{ALUOP_FN,  OPC_R,      F3_ADD,  F7_ALT};
            5'd2:    e = '{ALUOP_FN,  OPC_R,      F3_AND,  F7_BASE};
            5'd3:    e = '{ALUOP_FN,  OPC_R,      F3_OR,   F7_BASE};
            5'd4:    e = '{ALUOP_FN,  OPC_R,      F3_XOR,  F7_BASE};
            5'd5:    e = '{ALUOP_FN,  OPC_R,      F3_SLL,  F7_BASE};
            5'd6:    e = '{ALUOP_FN,  OPC_R,      F3_SR,   F7_BASE};
            5'd7:    e = '{ALUOP_FN,  OPC_R,      F3_SR,   F7_ALT};
            5'd8:    e = '{ALUOP_FN,  OPC_R,      F3_SLT,  F7_BASE};
            5'd9:    e = '{ALUOP_FN,  OPC_R,      F3_SLTU, F7_BASE};
            5'd10:   e = '{ALUOP_FN,  OPC_IMM,    F3_ADD,  F7_BASE};
            5'd11:   e = '{ALUOP_FN,  OPC_IMM,    F3_AND,  F7_BASE};
            5'd12:   e = '{ALUOP_FN,  OPC_IMM,    F3_OR,   F7_BASE};
            5'd13:   e = '{ALUOP_FN,  OPC_IMM,    F3_XOR,  F7_BASE};
            5'd14:   e = '{ALUOP_FN,  OPC_IMM,    F3_SLL,  F7_BASE};
            5'd15:   e = '{ALUOP_FN,  OPC_IMM,    F3_SR,   F7_BASE};
            5'd16:   e = '{ALUOP_FN,  OPC_IMM,    F3_SR,   F7_ALT};
            5'd17:   e = '{ALUOP_FN,  OPC_IMM,    F3_SLT,  F7_BASE};
            5'd18:   e = '{ALUOP_FN,  OPC_IMM,    F3_SLTU, F7_BASE};
            5'd19:   e = '{ALUOP_MEM, OPC_LOAD,   F3_LW,   F7_BASE};
            default: e = '{ALUOP_BR,  OPC_BRANCH, F3_BEQ,  F7_BASE};
        endcase
        return e;
    endfunction

    // Register and immediate fields stay zero: operands come straight from the LFSRs.
    function automatic logic [31:0] encode_instr(input op_entry_t e);
        return {e.funct7, 10'b0, e.funct3, 5'b0, e.opcode};
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Galois LFSR operand generator: clear/reset to zero, load seed, step when enabled.
// Latency: new value visible the cycle after load/enable.
// Backpressure: none; enable is the only stall control.
module bist_lfsr #(
    parameter int           W    = 32,
    parameter logic [W-1:0] SEED = {{(W-1){1'b0}}, 1'b1},
    parameter logic [W-1:0] POLY = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         enable,
    output logic [W-1:0] value
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            value <= '0;
        end else if (load) begin
            value <= SEED;
        end else if (enable) begin
            value <= {value[W-2:0], 1'b0} ^ (value[W-1] ? POLY : {W{1'b0}});
        end
    end

endmodule

// File: rtl/alu_bist.sv
// ALU self-test sequencer: walks 21 ops x PATTERNS LFSR operand pairs, folds results into a MISR, checks golden.
// Latency: one pattern per cycle; done 21*PATTERNS+2 cycles after the start edge.
// Backpressure: none; start is ignored while busy. ALU_BIST_OVF_EN folds alu_overflow into MISR bit 0.
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int           N                  = 32,
    parameter int           INSTRUCTION_LEN    = 32,
    parameter int           PATTERNS           = 256,
    parameter logic [N-1:0] EXPECTED_SIGNATURE = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [N-1:0]               signature,
    output logic [INSTRUCTION_LEN-1:0] alu_instruction,
    output logic [1:0]                 alu_op,
    output logic [N-1:0]               alu_data_1,
    output logic [N-1:0]               alu_data_2,
    input  logic [N-1:0]               alu_data_out,
    input  logic                       alu_overflow
);

    state_t      state;
    logic [4:0]  op_idx;
    logic [15:0] pat_cnt;
    logic        run_start;
    logic        in_run;
    logic        pat_wrap;
    logic        last_pat;
    op_entry_t   next_entry;
    logic [N-1:0] misr_in;

    assign run_start  = start && (state == IDLE || state == DONE);
    assign in_run     = (state == RUN);
    assign pat_wrap   = (pat_cnt == 16'(PATTERNS - 1));
    assign last_pat   = in_run && pat_wrap && (op_idx == 5'(NUM_OPS - 1));
    assign next_entry = op_table(run_start ? 5'd0 : op_idx + 5'd1);

`ifdef ALU_BIST_OVF_EN
    assign misr_in = alu_data_out ^ N'(alu_overflow);
`else
    logic ovf_unused;
    assign ovf_unused = alu_overflow;
    assign misr_in    = alu_data_out;
`endif

    // Operands are cleared on the last RUN cycle so COMPARE/DONE present zeros to the ALU.
    bist_lfsr #(.W(N), .SEED(N'(32'h0000_0001)), .POLY(N'(POLY))) u_lfsr_1 (
        .clk(clk), .reset(reset), .clear(last_pat), .load(run_start),
        .enable(in_run), .value(alu_data_1)
    );

    bist_lfsr #(.W(N), .SEED(N'(32'hACE1_0001)), .POLY(N'(POLY))) u_lfsr_2 (
        .clk(clk), .reset(reset), .clear(last_pat), .load(run_start),
        .enable(in_run), .value(alu_data_2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            signature       <= '1;
            alu_instruction <= '0;
            alu_op          <= 2'b00;
            op_idx          <= '0;
            pat_cnt         <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= RUN;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        signature       <= '1;
                        op_idx          <= '0;
                        pat_cnt         <= '0;
                        alu_instruction <= INSTRUCTION_LEN'(encode_instr(next_entry));
                        alu_op          <= next_entry.alu_op;
                    end
                end
                RUN: begin
                    signature <= {signature[N-2:0], 1'b0}
                               ^ (signature[N-1] ? N'(POLY) : {N{1'b0}})
                               ^ misr_in;
                    if (pat_wrap) begin
                        pat_cnt <= '0;
                        if (last_pat) begin
                            state           <= COMPARE;
                            op_idx          <= '0;
                            alu_instruction <= '0;
                            alu_op          <= 2'b00;
                        end else begin
                            op_idx          <= op_idx + 5'd1;
                            alu_instruction <= INSTRUCTION_LEN'(encode_instr(next_entry));
                            alu_op          <= next_entry.alu_op;
                        end
                    end else begin
                        pat_cnt <= pat_cnt + 16'd1;
                    end
                end
                COMPARE: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (signature == EXPECTED_SIGNATURE);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: a behavioural ALU closes the loop; directed vectors plus reset/restart/fault sequences.
module tb_alu_bist;

    localparam logic [0:20][31:0] INSTR_TAB = '{
        32'h0000_0033, 32'h4000_0033, 32'h0000_7033, 32'h0000_6033, 32'h0000_4033,
        32'h0000_1033, 32'h0000_5033, 32'h4000_5033, 32'h0000_2033, 32'h0000_3033,
        32'h0000_0013, 32'h0000_7013, 32'h0000_6013, 32'h0000_4013, 32'h0000_1013,
        32'h0000_5013, 32'h4000_5013, 32'h0000_2013, 32'h0000_3013,
        32'h0000_2003, 32'h0000_0063};
    localparam logic [0:20][1:0] ALUOP_TAB = '{
        2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
        2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
        2'b00, 2'b01};

`ifdef ALU_BIST_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    function automatic logic [31:0] crc_step(input logic [31:0] v);
        return {v[30:0], 1'b0} ^ (v[31] ? 32'h04C1_1DB7 : 32'h0);
    endfunction

    function automatic logic [31:0] alu_fn(input logic [31:0] ins, input logic [1:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        alt;
        alt = ins[30];
        r   = 32'h0;
        if (op == 2'b00) r = a + b;
        else if (op == 2'b01) r = a - b;
        else begin
            case (ins[14:12])
                3'd0: r = alt ? a - b : a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = {31'b0, $signed(a) < $signed(b)};
                3'd3: r = {31'b0, a < b};
                3'd4: r = a ^ b;
                3'd5: r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] model_sig(input int p, input bit stuck, input bit ovf);
        logic [31:0] l1, l2, s, r;
        l1 = 32'h0000_0001;
        l2 = 32'hACE1_0001;
        s  = 32'hFFFF_FFFF;
        for (int op = 0; op < 21; op++) begin
            for (int k = 0; k < p; k++) begin
                r = alu_fn(INSTR_TAB[op], ALUOP_TAB[op], l1, l2);
                if (stuck) r[0] = 1'b0;
                if (ovf) r[0] = ~r[0];
                s  = crc_step(s) ^ r;
                l1 = crc_step(l1);
                l2 = crc_step(l2);
            end
        end
        return s;
    endfunction

    localparam logic [31:0] GOLD1 = model_sig(1, 1'b0, 1'b0);

    logic        clk = 1'b0;
    logic        rst1, start1, busy1, done1, pass1, ovf1;
    logic [31:0] sig1, ins1, a1, b1, dout1;
    logic [1:0]  op1;
    logic        rst2, start2, busy2, done2, pass2, ovf2;
    logic [31:0] sig2, ins2, a2, b2, dout2;
    logic [1:0]  op2;
    logic        stuck1 = 1'b0;
    logic        ovf_force = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        dout1 = alu_fn(ins1, op1, a1, b1);
        if (stuck1) dout1[0] = 1'b0;
    end
    assign ovf1  = ovf_force;
    assign dout2 = alu_fn(ins2, op2, a2, b2);
    assign ovf2  = 1'b0;

    alu_bist #(.PATTERNS(1), .EXPECTED_SIGNATURE(GOLD1)) dut1 (
        .clk(clk), .reset(rst1), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
        .signature(sig1), .alu_instruction(ins1), .alu_op(op1), .alu_data_1(a1),
        .alu_data_2(b1), .alu_data_out(dout1), .alu_overflow(ovf1));

    alu_bist #(.PATTERNS(256)) dut256 (
        .clk(clk), .reset(rst2), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
        .signature(sig2), .alu_instruction(ins2), .alu_op(op2), .alu_data_1(a2),
        .alu_data_2(b2), .alu_data_out(dout2), .alu_overflow(ovf2));

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  aluop;
    } vec_t;

    vec_t vecs[21];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Returns at the negedge of cycle t+1, t being the edge that samples start.
    task automatic pulse_start1();
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
    endtask

    task automatic pulse_start2();
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
    endtask

    task automatic wait_done1(input int n0, output int lat);
        lat = n0;
        while (done1 !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_done2(input int n0, output int lat);
        lat = n0;
        while (done2 !== 1'b1 && lat < 6000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] m1, m2, gold256;

        for (int i = 0; i < 21; i++) begin
            vecs[i].instr = INSTR_TAB[i];
            vecs[i].aluop = ALUOP_TAB[i];
        end

        rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy",  32'(busy1), 32'h0);
        check("reset done",  32'(done1), 32'h0);
        check("reset pass",  32'(pass1), 32'h0);
        check("reset sig",   sig1, 32'hFFFF_FFFF);
        check("reset instr", ins1, 32'h0);
        check("reset aluop", 32'(op1), 32'h0);
        check("reset data1", a1, 32'h0);
        check("reset data2", b1, 32'h0);
        rst1 = 1'b0; rst2 = 1'b0;

        // Golden run, PATTERNS=1: every op presented once with the model's operands.
        m1 = 32'h0000_0001;
        m2 = 32'hACE1_0001;
        pulse_start1();
        check("busy at t+1", 32'(busy1), 32'h1);
        for (int k = 0; k < 21; k++) begin
            check($sformatf("op%0d instr", k), ins1, vecs[k].instr);
            check($sformatf("op%0d aluop", k), 32'(op1), 32'(vecs[k].aluop));
            check($sformatf("op%0d data1", k), a1, m1);
            check($sformatf("op%0d data2", k), b1, m2);
            m1 = crc_step(m1);
            m2 = crc_step(m2);
            @(negedge clk);
        end
        check("compare busy", 32'(busy1), 32'h1);
        wait_done1(22, lat);
        check("golden latency", lat, 23);
        check("golden pass", 32'(pass1), 32'h1);
        check("golden sig", sig1, GOLD1);
        check("done busy", 32'(busy1), 32'h0);
        check("done instr", ins1, 32'h0);

        // Restart from DONE, with a stray start in the middle of RUN.
        pulse_start1();
        check("restart done clr", 32'(done1), 32'h0);
        check("restart busy", 32'(busy1), 32'h1);
        repeat (3) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        wait_done1(5, lat);
        check("restart latency", lat, 23);
        check("restart sig", sig1, GOLD1);

        // Stuck-at-0 on result bit 0.
        stuck1 = 1'b1;
        pulse_start1();
        wait_done1(1, lat);
        stuck1 = 1'b0;
        check("stuck latency", lat, 23);
        check("stuck pass", 32'(pass1), 32'h0);
        check("stuck sig", sig1, model_sig(1, 1'b1, 1'b0));
        check("stuck sig differs", 32'(sig1 != GOLD1), 32'h1);

        // Overflow forced high: only folded in when the feature is built in.
        ovf_force = 1'b1;
        pulse_start1();
        wait_done1(1, lat);
        ovf_force = 1'b0;
        check("ovf latency", lat, 23);
        check("ovf sig", sig1, model_sig(1, 1'b0, OVF_ON));
        check("ovf pass", 32'(pass1), OVF_ON ? 32'h0 : 32'h1);

        // PATTERNS=256: reset at cycle 100 of the run, then a clean run.
        gold256 = model_sig(256, 1'b0, 1'b0);
        pulse_start2();
        repeat (99) @(negedge clk);
        check("p256 busy mid", 32'(busy2), 32'h1);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        check("mid reset busy",  32'(busy2), 32'h0);
        check("mid reset done",  32'(done2), 32'h0);
        check("mid reset pass",  32'(pass2), 32'h0);
        check("mid reset sig",   sig2, 32'hFFFF_FFFF);
        check("mid reset instr", ins2, 32'h0);
        check("mid reset aluop", 32'(op2), 32'h0);
        check("mid reset data1", a2, 32'h0);
        check("mid reset data2", b2, 32'h0);
        pulse_start2();
        check("p256 data2 first", b2, 32'hACE1_0001);
        wait_done2(1, lat);
        check("p256 latency", lat, 21 * 256 + 2);
        check("p256 sig", sig2, gold256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
